// File: rtl/rns_conv_sched_pkg.sv
// Shared widths and packing helpers for the RNS conversion scheduler.
// Residues are carried as {mod8, mod7, mod5, mod3} in an 11-bit response word.
package rns_conv_sched_pkg;

  localparam int OPND_W = 10;
  localparam int MOD8_W = 3;
  localparam int MOD7_W = 3;
  localparam int MOD5_W = 3;
  localparam int MOD3_W = 2;
  localparam int RSP_W  = MOD8_W + MOD7_W + MOD5_W + MOD3_W;

  typedef struct packed {
    logic [MOD8_W-1:0] m8;
    logic [MOD7_W-1:0] m7;
    logic [MOD5_W-1:0] m5;
    logic [MOD3_W-1:0] m3;
  } rns_res_t;

  function automatic rns_res_t rns_pack(input logic [MOD8_W-1:0] m8,
                                        input logic [MOD7_W-1:0] m7,
                                        input logic [MOD5_W-1:0] m5,
                                        input logic [MOD3_W-1:0] m3);
    rns_res_t r;
    r.m8 = m8;
    r.m7 = m7;
    r.m5 = m5;
    r.m3 = m3;
    return r;
  endfunction

endpackage

// File: rtl/rns_rr_arbiter.sv
// Round-robin grant over NREQ requesters; the pointer moves only when the
// granted requester is actually accepted.
module rns_rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  input  logic            accept_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o
);

  logic [IDW-1:0] last_q, last_d;
  logic           found;

  // Search order starts one past the last winner and wraps around.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && en_i && req_i[i] &&
            (((int'(last_q) + off) % NREQ) == i)) begin
          gnt_o[i]  = 1'b1;
          gnt_idx_o = IDW'(i);
          found     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (accept_i) last_d = gnt_idx_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= IDW'(NREQ - 1);
    else       last_q <= last_d;
  end

endmodule

// File: rtl/rns_conv_sched.sv
// Schedules requester operands onto a shared binary-to-RNS converter and
// returns the residues in issue order through a credit-protected response FIFO.
module rns_conv_sched
  import rns_conv_sched_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int LAT   = 2,
  parameter  int DEPTH = 4,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [OPND_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [OPND_W-1:0]      conv_n,
  input  logic [MOD8_W-1:0]      conv_mod8,
  input  logic [MOD7_W-1:0]      conv_mod7,
  input  logic [MOD5_W-1:0]      conv_mod5,
  input  logic [MOD3_W-1:0]      conv_mod3,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [RSP_W-1:0]       rsp_data,
  output logic                   busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [OPND_W-1:0] req_arr [NREQ];
  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_idx;
  logic              can_issue, issue, push, pop, fifo_empty;

  logic [CW-1:0]     outst_q, outst_d;
  logic [OPND_W-1:0] conv_n_q, conv_n_d;
  logic [LAT-1:0]    tag_vld_q;
  logic [IDW-1:0]    tag_id_q [LAT];

  logic [IDW-1:0]    fifo_id_q  [DEPTH];
  logic [RSP_W-1:0]  fifo_dat_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     fcnt_q, fcnt_d;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_arr[g] = req_data[OPND_W*g +: OPND_W];
  end

  // Credit counts every accepted request not yet popped, so a pop in this
  // cycle only frees a slot for the following cycle.
  assign can_issue = !rst && (outst_q < CW'(DEPTH));

  rns_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req_valid),
    .en_i      (can_issue),
    .accept_i  (issue),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign req_ready  = gnt;
  assign issue      = |(req_valid & gnt);
  assign push       = tag_vld_q[LAT-1];
  assign fifo_empty = (fcnt_q == '0);
  assign pop        = !fifo_empty && rsp_ready;

  always_comb begin
    conv_n_d = conv_n_q;
    if (issue) conv_n_d = req_arr[gnt_idx];

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    fcnt_d = fcnt_q;
    if (push && !pop)      fcnt_d = fcnt_q + 1'b1;
    else if (pop && !push) fcnt_d = fcnt_q - 1'b1;

    outst_d = outst_q;
    if (issue && !pop)      outst_d = outst_q + 1'b1;
    else if (pop && !issue) outst_d = outst_q - 1'b1;
  end

  // Stage boundary: operand register and tag pipeline (control reset only).
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_n_q  <= '0;
      tag_vld_q <= '0;
      outst_q   <= '0;
    end else begin
      conv_n_q     <= conv_n_d;
      outst_q      <= outst_d;
      tag_vld_q[0] <= issue;
      for (int s = 1; s < LAT; s++) tag_vld_q[s] <= tag_vld_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_id_q[0] <= gnt_idx;
    for (int s = 1; s < LAT; s++) tag_id_q[s] <= tag_id_q[s-1];
  end

  // Stage boundary: response FIFO capture of id plus converter residues.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id_q[wr_ptr_q]  <= tag_id_q[LAT-1];
      fifo_dat_q[wr_ptr_q] <= rns_pack(conv_mod8, conv_mod7, conv_mod5, conv_mod3);
    end
  end

  assign conv_n    = conv_n_q;
  assign rsp_valid = !fifo_empty;
  assign rsp_id    = fifo_empty ? '0 : fifo_id_q[rd_ptr_q];
  assign rsp_data  = fifo_empty ? '0 : fifo_dat_q[rd_ptr_q];
  assign busy      = (|tag_vld_q) || !fifo_empty;

endmodule

// File: tb/tb_rns_conv_sched.sv
// Bench for rns_conv_sched: a two-cycle converter model plus a queue-based
// reference of outstanding requests checked every cycle.
module tb_rns_conv_sched;

  localparam int NREQ  = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [39:0] req_data;
  logic [3:0]  req_ready;
  logic [9:0]  conv_n;
  logic [2:0]  conv_mod8, conv_mod7, conv_mod5;
  logic [1:0]  conv_mod3;
  logic        rsp_valid, rsp_ready, busy;
  logic [1:0]  rsp_id;
  logic [10:0] rsp_data;

  rns_conv_sched #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .conv_n(conv_n), .conv_mod8(conv_mod8),
    .conv_mod7(conv_mod7), .conv_mod5(conv_mod5), .conv_mod3(conv_mod3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] resid(input logic [9:0] v);
    int s, a, b, c, e;
    s = int'($signed(v));
    a = ((s % 8) + 8) % 8;
    b = ((s % 7) + 7) % 7;
    c = ((s % 5) + 5) % 5;
    e = ((s % 3) + 3) % 3;
    return {a[2:0], b[2:0], c[2:0], e[1:0]};
  endfunction

  // Converter: residues of conv_n appear LAT cycles after conv_n changes.
  logic [9:0]  conv_r;
  logic [10:0] cres;
  always @(posedge clk) conv_r <= conv_n;
  assign cres      = resid(conv_r);
  assign conv_mod8 = cres[10:8];
  assign conv_mod7 = cres[7:5];
  assign conv_mod5 = cres[4:2];
  assign conv_mod3 = cres[1:0];

  typedef struct { int id; logic [9:0] val; int t; } item_t;
  item_t q[$];
  int errs = 0, nchk = 0;
  int cyc = 0, last = NREQ - 1;
  logic [9:0] conv_m = '0;
  logic dut_hs, dut_pop2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive, compare against the reference, then advance both.
  task automatic cycle(input logic r, input logic [3:0] v, input logic [39:0] d, input logic rr);
    logic [3:0] eg;
    int gi, c;
    logic vis;
    rst = r; req_valid = v; req_data = d; rsp_ready = rr;
    #1;
    vis = (q.size() > 0) && (cyc - q[0].t >= LAT);
    eg = '0; gi = -1;
    if (!r && (DEPTH - q.size()) > 0 && (|v))
      for (int k = 1; k <= NREQ; k++) begin
        c = (last + k) % NREQ;
        if (gi < 0 && v[c]) gi = c;
      end
    if (gi >= 0) eg[gi] = 1'b1;
    chk("req_ready", req_ready, eg);
    chk("rsp_valid", rsp_valid, vis);
    chk("rsp_id",    rsp_id,   vis ? q[0].id : 0);
    chk("rsp_data",  rsp_data, vis ? resid(q[0].val) : 11'd0);
    chk("busy",      busy,     q.size() > 0);
    chk("conv_n",    conv_n,   conv_m);
    dut_hs   = |(req_valid & req_ready);
    dut_pop2 = rsp_valid && rsp_ready && (rsp_id == 2'd2);
    @(posedge clk);
    if (r) begin
      q.delete();
      last   = NREQ - 1;
      conv_m = '0;
    end else begin
      if (vis && rr) void'(q.pop_front());
      if (gi >= 0) begin
        q.push_back('{gi, d[gi*10 +: 10], cyc + 1});
        last   = gi;
        conv_m = d[gi*10 +: 10];
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 40'd0, 1'b1);
  endtask

  int acc, cnt2;
  logic [39:0] d;
  logic [63:0] r64;

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'hF;
    #1;
    chk("rst_req_ready", req_ready, 4'h0);
    chk("rst_conv_n", conv_n, 10'd0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 2'd0);
    chk("rst_rsp_data", rsp_data, 11'd0);
    chk("rst_busy", busy, 1'b0);

    // Single request from requester 0 with value 100.
    cycle(1'b0, 4'b0001, 40'd100, 1'b1);
    idle(2);
    chk("s40_id", rsp_id, 2'd0);
    chk("s40_data", rsp_data, {3'd4, 3'd2, 3'd0, 2'd1});
    idle(2);

    // Requester 1 with value -1.
    cycle(1'b0, 4'b0010, {10'd0, 10'd0, 10'h3FF, 10'd0}, 1'b1);
    idle(2);
    chk("s41_id", rsp_id, 2'd1);
    chk("s41_data", rsp_data, {3'd7, 3'd6, 3'd4, 2'd2});
    idle(3);

    // All requesters continuously valid.
    for (int i = 0; i < 12; i++) cycle(1'b0, 4'hF, {10'd40, 10'd30, 10'd20, 10'd10 + 10'(i)}, 1'b1);
    idle(5);

    // Consumer stalled: credit must stop issuing at DEPTH.
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 4'hF, {10'd513, 10'd1000, 10'd7, 10'd300}, 1'b0);
      acc += int'(dut_hs);
    end
    chk("s43_accepts", acc, DEPTH);
    chk("s43_busy", busy, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 4'hF, {10'd2, 10'd3, 10'd4, 10'd5}, 1'b1);
    idle(5);

    // Reset with work in flight.
    cycle(1'b0, 4'hF, {10'd11, 10'd22, 10'd33, 10'd44}, 1'b1);
    cycle(1'b0, 4'hF, {10'd11, 10'd22, 10'd33, 10'd44}, 1'b1);
    cycle(1'b1, 4'h0, 40'd0, 1'b1);
    idle(4);
    chk("s44_busy", busy, 1'b0);
    rst = 1'b0; req_valid = 4'hF;
    #1;
    chk("s44_gnt", req_ready, 4'b0001);
    idle(1);

    // Only requester 2 held valid.
    acc = 0; cnt2 = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 4'b0100, {10'd0, 10'(i * 37), 10'd0, 10'd0}, 1'b1);
      acc += int'(dut_hs); cnt2 += int'(dut_pop2);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'h0, 40'd0, 1'b1);
      cnt2 += int'(dut_pop2);
    end
    chk("s45_accepts", acc, 12);
    chk("s45_responses", cnt2, 12);

    // Randomized traffic, backpressure and occasional reset.
    for (int i = 0; i < 500; i++) begin
      r64 = {$urandom(), $urandom()};
      d = r64[39:0];
      cycle($urandom_range(0, 60) == 0, 4'($urandom_range(0, 15)), d,
            $urandom_range(0, 3) != 0);
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/rns_conv_sched.md
RNS_CONV_SCHED -- requirements
Module: rns_conv_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the binary-to-RNS converter.
REQ-002 Parameter LAT, default 2: cycles from a conv_n update to valid converter residues.
REQ-003 Parameter DEPTH, default 4: response FIFO entries.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req_valid  in  NREQ  per-requester request valid.
REQ-008 req_data  in  10*NREQ  requester i value at [10i+9:10i], two's complement.
REQ-009 req_ready  out  NREQ  one-hot grant, combinational.
REQ-010 conv_n  out  10  registered operand to the converter.
REQ-011 conv_mod8, conv_mod7, conv_mod5  in  3 each  converter residues.
REQ-012 conv_mod3  in  2  converter residue.
REQ-013 rsp_valid  out  1  response available.
REQ-014 rsp_ready  in  1  response consumer accepts.
REQ-015 rsp_id  out  clog2(NREQ)  originating requester.
REQ-016 rsp_data  out  11  {mod8,mod7,mod5,mod3}.
REQ-017 busy  out  1  any request in flight or any response queued.

Function
REQ-018 Credit SHALL equal DEPTH minus (in-flight tags + FIFO occupancy), computed from registered state only.
REQ-019 A same-cycle pop SHALL NOT enable an issue in that cycle.
REQ-020 When credit>0 and any req_valid is high, exactly one req_ready bit SHALL be high; otherwise all SHALL be 0.
REQ-021 The grant SHALL be round-robin: search starts at last granted index+1 mod NREQ, and last granted = NREQ-1 after reset, so requester 0 wins first.
REQ-022 The grant pointer SHALL advance only on handshake (req_valid&req_ready).
REQ-023 On handshake at edge T, conv_n SHALL load the granted req_data and a tag {valid,id} SHALL enter stage 0 of an LAT-deep shift register.
REQ-024 conv_n SHALL hold its value on cycles with no handshake.
REQ-025 At edge T+LAT, when the last tag stage is valid, {id, conv residues} SHALL be pushed into the FIFO; rsp_valid is visible after that edge.
REQ-026 Throughput SHALL be one issue per cycle.
REQ-027 The FIFO SHALL be first-word-fall-through and pop on rsp_valid&rsp_ready.
REQ-028 Simultaneous push and pop SHALL keep occupancy unchanged.
REQ-029 The FIFO SHALL never overflow (guaranteed by REQ-018) and its pointers SHALL wrap modulo DEPTH.
REQ-030 When empty, rsp_valid, rsp_id and rsp_data SHALL be 0.
REQ-031 Responses SHALL leave in issue order.
REQ-032 The block SHALL never alter residues.
REQ-033 busy SHALL be registered-state derived: tag pipeline nonempty OR FIFO nonempty.

Reset
REQ-034 On rst, conv_n, rsp_valid, rsp_id, rsp_data and busy SHALL be 0, all tags cleared, FIFO emptied and grant pointer set per REQ-021.
REQ-035 req_ready SHALL be 0 during the reset cycle.
REQ-036 Reset mid-operation SHALL silently discard in-flight and queued results; none appear after reset release.

Structure
REQ-037 A shared package SHALL hold the RNS residue field widths (3,3,3,2), the 11-bit response packing, and the 10-bit operand width.
REQ-038 One sub-module, rns_rr_arbiter (NREQ-wide round-robin grant with pointer update on accept), SHALL be used.
REQ-039 The FIFO and tag pipeline SHALL be inline.

Verification (bench models converter with LAT=2)
REQ-040 Scenario: req_valid[0]=1, req_data0=100, rsp_ready=1 -> 2 cycles later rsp_valid=1, rsp_id=0, mod8=4, mod7=2, mod5=0, mod3=1.
REQ-041 Scenario: req_data1=10'h3FF (-1) -> rsp_id=1, mod8=7, mod7=6, mod5=4, mod3=2.
REQ-042 Scenario: all four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle, rsp_id sequence identical.
REQ-043 Scenario: rsp_ready=0, all valid -> exactly 4 accepts then req_ready=0 and busy=1; raise rsp_ready -> 4 responses drain in order, issuing resumes the cycle after the first pop.
REQ-044 Scenario: accept 2 requests, assert rst 1 cycle -> no rsp_valid afterwards, busy=0, next grant to requester 0.
REQ-045 Scenario: only req_valid[2] held high -> accepted every cycle, one response per cycle, all rsp_id=2.
